// File: rtl/rotation_line_parser.sv
// ASCII rotation-line parser: turns "L68\n"-style lines into (value, positive) records.
// Optional macro ROTATION_LINE_PARSER_CRLF_EN makes 0x0D a silently skipped byte.
module rotation_line_parser #(
  parameter int MAX_DIGITS = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] value,
  output logic        positive,
  output logic [15:0] line_count,
  output logic        error,
  output logic [7:0]  error_count
);

  localparam int NDIG_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIGITS, S_DISCARD} state_t;

  state_t              r_state, w_state_next;
  logic [15:0]         r_acc, w_acc_next;
  logic [NDIG_W-1:0]   r_ndig, w_ndig_next;
  logic                r_dir, w_dir_next;
  logic                r_out_valid;
  logic [15:0]         r_value;
  logic                r_positive;
  logic [15:0]         r_line_count;
  logic                r_error;
  logic [7:0]          r_error_count;

  logic                w_accept, w_is_digit, w_is_nl, w_skip;
  logic                w_emit, w_line_err, w_overflow;
  logic [19:0]         w_acc_wide;

  assign in_ready    = !r_out_valid;
  assign out_valid   = r_out_valid;
  assign value       = r_value;
  assign positive    = r_positive;
  assign line_count  = r_line_count;
  assign error       = r_error;
  assign error_count = r_error_count;

  assign w_accept   = in_valid && !r_out_valid;
  assign w_is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
  assign w_is_nl    = (in_byte == 8'h0A);
  // Widened so a 5-digit value times ten cannot wrap before the range check.
  assign w_acc_wide = {4'd0, r_acc} * 20'd10 + {16'd0, in_byte[3:0]};
  assign w_overflow = (r_ndig == NDIG_W'(MAX_DIGITS)) || (w_acc_wide > 20'd65535);

`ifdef ROTATION_LINE_PARSER_CRLF_EN
  assign w_skip = (in_byte == 8'h0D);
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_ndig_next  = r_ndig;
    w_dir_next   = r_dir;
    w_emit       = 1'b0;
    w_line_err   = 1'b0;
    if (w_accept && !w_skip) begin
      case (r_state)
        S_IDLE: begin
          if (in_byte == 8'h4C || in_byte == 8'h52) begin
            w_state_next = S_DIGITS;
            w_dir_next   = (in_byte == 8'h52);
            w_acc_next   = 16'd0;
            w_ndig_next  = '0;
          end else if (!w_is_nl) begin
            w_state_next = S_DISCARD;
          end
        end
        S_DIGITS: begin
          if (w_is_digit) begin
            if (w_overflow) begin
              w_state_next = S_DISCARD;
            end else begin
              w_acc_next  = w_acc_wide[15:0];
              w_ndig_next = r_ndig + NDIG_W'(1);
            end
          end else if (w_is_nl) begin
            w_state_next = S_IDLE;
            if (r_ndig != '0) w_emit = 1'b1;
            else              w_line_err = 1'b1;
          end else begin
            w_state_next = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (w_is_nl) begin
            w_state_next = S_IDLE;
            w_line_err   = 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_acc   <= 16'd0;
      r_ndig  <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_ndig  <= w_ndig_next;
      r_dir   <= w_dir_next;
    end
  end

  // Emit and handshake never coincide: bytes are only accepted while out_valid is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid   <= 1'b0;
      r_value       <= 16'd0;
      r_positive    <= 1'b0;
      r_line_count  <= 16'd0;
      r_error       <= 1'b0;
      r_error_count <= 8'd0;
    end else begin
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_value     <= r_acc;
        r_positive  <= r_dir;
      end else if (r_out_valid && out_ready) begin
        r_out_valid  <= 1'b0;
        r_line_count <= r_line_count + 16'd1;
      end
      if (w_line_err) begin
        r_error <= 1'b1;
        if (r_error_count != 8'hFF) r_error_count <= r_error_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/rotation_line_parser.md
Name: rotation_line_parser

Overview:
Upstream stage of the dial datapath. Consumes the raw puzzle input as an ASCII byte stream, one rotation per line (e.g. "L68\n", "R48\n"). Produces one decoded rotation per line: magnitude on `value`, direction on `positive`. `out_valid` is the datapath's advance qualifier, so the dial moves exactly once per rotation and never on idle cycles.

Parameters:
MAX_DIGITS, 5, maximum decimal digits accepted per line; a longer digit run is a format error.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  byte_in is valid this cycle
in_byte  input  8  ASCII input byte
in_ready  output  1  parser accepts in_byte this cycle
out_valid  output  1  decoded rotation available
out_ready  input  1  downstream consumes rotation this cycle
value  output  16  rotation magnitude (unsigned, unreduced)
positive  output  1  1 = 'R' (clockwise, add), 0 = 'L' (subtract)
line_count  output  16  rotations emitted since reset
error  output  1  sticky: at least one malformed line seen
error_count  output  8  malformed lines discarded, saturating at 255

Behaviour:
- Reset is asynchronous, active-low: clock and reset as above; reset asserted low clears all state immediately.
  - Values while reset is low: state=IDLE, acc=0, digit count=0, out_valid=0, value=0, positive=0, line_count=0, error=0, error_count=0.
  - Reset low mid-line or mid-emit discards the partial line and any pending output.
- Byte transfer occurs when in_valid && in_ready. in_ready = !out_valid (no skid buffer).
- States:
  - IDLE:
    - 'L'(0x4C) → DIGITS, dir=0, acc=0, ndig=0.
    - 'R'(0x52) → DIGITS, dir=1, acc=0, ndig=0.
    - '\n'(0x0A) → stay in IDLE; blank lines are ignored.
    - Any other byte → DISCARD.
  - DIGITS:
    - '0'..'9': acc ← acc*10 + (byte−0x30), computed in 20-bit then checked; ndig++.
      - If ndig would exceed MAX_DIGITS, or the result exceeds 65535 → DISCARD.
    - '\n' with ndig≥1: value←acc[15:0], positive←dir, out_valid←1 on the next edge; → IDLE.
    - '\n' with ndig=0: error←1, error_count++ (saturating); → IDLE.
    - Any other byte → DISCARD.
  - DISCARD: swallow bytes until '\n'. On that '\n': error←1, error_count++ (saturating); → IDLE.
- Output hold: value and positive are stable while out_valid=1. out_valid clears on the cycle after out_valid && out_ready. line_count increments on that same handshake, wrapping 65535→0.
- Latency: '\n' accepted at edge N → out_valid=1 after edge N. If out_ready is held high, at most one rotation is emitted per two cycles.
- Simultaneous events: a byte cannot be accepted while out_valid=1, so parse and emit never overlap.
- Value 0 (e.g. "R0\n") is a legal rotation and is emitted.
- Leading zeros count toward MAX_DIGITS.
- in_byte is ignored when in_valid=0.

Optional Feature:
ROTATION_LINE_PARSER_CRLF_EN
- Defined: byte 0x0D is silently skipped in every state (Windows line endings accepted); it does not count as a digit and does not break a digit run.
- Undefined: 0x0D is an ordinary illegal byte. In IDLE or DIGITS it sends the parser to DISCARD, and the line is counted as an error.

Test Plan:
1. Reset low, then high. Stream "L68\nR48\n" with out_ready=1 → two emits:
   - value=68, positive=0
   - value=48, positive=1
   - Final state: line_count=2, error=0.
2. Stream "R1000\n" with out_ready=0 for 5 cycles after the emit:
   - out_valid stays 1, value=1000 and positive=1 stay stable.
   - in_ready=0 and the next byte is stalled.
   - Raising out_ready completes the transfer; line_count=1.
3. Stream "R65535\nL65536\nR123456\n" → only value=65535 is emitted; error=1, error_count=2.
4. Stream "X5\nL\n\nR7\n":
   - Outputs: a single emit, value=7, positive=1.
   - Counters: error_count=2 (the "X5" line and the empty-digit "L" line); the blank line is ignored.
5. Stream "L3" then drop reset low for one cycle, then stream "9\nR2\n" → only value=2 is emitted; the "9" line is not counted (IDLE sees '9' → DISCARD → error_count=1).
6. Stream "R12\r\n":
   - With ROTATION_LINE_PARSER_CRLF_EN: value=12 emitted, error=0.
   - Without it: no emit, error_count=1.
